// File: rtl/iram_access_arbiter_pkg.sv
// rtl/iram_access_arbiter_pkg.sv - shared states, requester ids and defaults for the IRAM arbiter
package iram_access_arbiter_pkg;

    localparam int DRAIN_CYCLES_DEF = 3;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 3'd0;
    localparam arb_state_t ST_DRAIN  = 3'd1;
    localparam arb_state_t ST_GRANT  = 3'd2;
    localparam arb_state_t ST_RDATA  = 3'd3;
    localparam arb_state_t ST_NEXT   = 3'd4;
    localparam arb_state_t ST_RESUME = 3'd5;

    typedef enum logic {
        REQ_MON = 1'b0,
        REQ_LD  = 1'b1
    } req_id_t;

endpackage

// File: rtl/iram_access_arbiter_rr_pick.sv
// rtl/iram_access_arbiter_rr_pick.sv - two-requester round-robin picker, one-hot grant {ld, mon}
module iram_rr_pick
    import iram_access_arbiter_pkg::*;
(
    input  logic       mon_req,
    input  logic       ld_req,
    input  req_id_t    rr_last,
    output logic [1:0] grant
);

    // On contention the requester that was not served last wins.
    assign grant[0] = mon_req & (~ld_req | (rr_last == REQ_LD));
    assign grant[1] = ld_req & (~mon_req | (rr_last == REQ_MON));

endmodule

// File: rtl/iram_access_arbiter.sv
// rtl/iram_access_arbiter.sv - shares the instruction-RAM port between fetch, UART monitor and boot loader
module iram_access_arbiter
    import iram_access_arbiter_pkg::*;
#(
    parameter int IWIDTH       = 12,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_run,
    input  logic              mon_req,
    input  logic              mon_we,
    input  logic [IWIDTH-1:0] mon_adr,
    input  logic [31:0]       mon_wdata,
    output logic              mon_ack,
    output logic [31:0]       mon_rdata,
    input  logic              ld_req,
    input  logic [IWIDTH-1:0] ld_adr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic              cpu_halt,
    output logic              rst_pipe,
    output logic              i_read_sel,
    output logic [IWIDTH-1:0] i_ram_radr,
    input  logic [31:0]       i_ram_rdata,
    output logic [IWIDTH-1:0] i_ram_wadr,
    output logic [31:0]       i_ram_wdata,
    output logic              i_ram_wen
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    arb_state_t state;
    logic [3:0] drain_cnt;
    req_id_t    rr_last;
    logic       done;
    logic       rd_ack_q;
    logic [1:0] grant;
    logic       any_req;
    logic       wr_go;
    logic       rd_go;
    logic       other_pending;

    iram_rr_pick u_pick (
        .mon_req (mon_req),
        .ld_req  (ld_req),
        .rr_last (rr_last),
        .grant   (grant)
    );

    assign any_req = mon_req | ld_req;
    assign wr_go   = (state == ST_GRANT) & (grant[1] | (grant[0] & mon_we));
    assign rd_go   = (state == ST_GRANT) & grant[0] & ~mon_we;
    // The requester just acked is still dropping its req, so only the other one counts.
    assign other_pending = (rr_last == REQ_MON) ? ld_req : mon_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= 4'd0;
            rr_last   <= REQ_LD;
            done      <= 1'b0;
            rd_ack_q  <= 1'b0;
            mon_rdata <= 32'd0;
        end else begin
            rd_ack_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (any_req) begin
                        if (cpu_run) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= ST_GRANT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!any_req) begin
                        state <= ST_RESUME;
                    end else if (drain_cnt == 4'd0) begin
                        state <= ST_GRANT;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (grant[1]) begin
                        rr_last <= REQ_LD;
                        done    <= 1'b1;
                        state   <= ST_NEXT;
                    end else if (grant[0]) begin
                        rr_last <= REQ_MON;
                        if (mon_we) begin
                            done  <= 1'b1;
                            state <= ST_NEXT;
                        end else begin
                            state <= ST_RDATA;
                        end
                    end else begin
                        state <= ST_RESUME;
                    end
                end
                ST_RDATA: begin
                    mon_rdata <= i_ram_rdata;
                    rd_ack_q  <= 1'b1;
                    done      <= 1'b1;
                    state     <= ST_NEXT;
                end
                ST_NEXT: begin
                    state <= other_pending ? ST_GRANT : ST_RESUME;
                end
                ST_RESUME: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_halt    = (state == ST_DRAIN) | (state == ST_GRANT) |
                         (state == ST_RDATA) | (state == ST_NEXT);
    assign rst_pipe    = (state == ST_RESUME) & done;
    assign i_read_sel  = rd_go | (state == ST_RDATA);
    assign i_ram_radr  = i_read_sel ? mon_adr : '0;
    assign i_ram_wen   = wr_go;
    assign i_ram_wadr  = wr_go ? (grant[1] ? ld_adr : mon_adr) : '0;
    assign i_ram_wdata = wr_go ? (grant[1] ? ld_wdata : mon_wdata) : 32'd0;
    assign mon_ack     = (wr_go & grant[0]) | rd_ack_q;
    assign ld_ack      = wr_go & grant[1];

endmodule

// File: tb/tb_iram_access_arbiter.sv
// tb/tb_iram_access_arbiter.sv - table-driven self-checking bench for iram_access_arbiter
module tb_iram_access_arbiter;

    localparam int IW = 12;
    localparam logic [IW-1:0] MADR = 12'h020;
    localparam logic [IW-1:0] LADR = 12'h010;
    localparam logic [31:0]   MWD  = 32'hDEADBEEF;
    localparam logic [31:0]   LWD  = 32'h00000013;
    localparam logic [31:0]   DB   = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_run, mon_req, mon_we, ld_req;
    logic [IW-1:0] mon_adr, ld_adr;
    logic [31:0]   mon_wdata, ld_wdata;
    logic          mon_ack, ld_ack, cpu_halt, rst_pipe, i_read_sel, i_ram_wen;
    logic [31:0]   mon_rdata, i_ram_rdata, i_ram_wdata;
    logic [IW-1:0] i_ram_radr, i_ram_wadr;

    logic [31:0] mem [0:(1<<IW)-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iram_access_arbiter #(.IWIDTH(IW), .DRAIN_CYCLES(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_run     (cpu_run),
        .mon_req     (mon_req),
        .mon_we      (mon_we),
        .mon_adr     (mon_adr),
        .mon_wdata   (mon_wdata),
        .mon_ack     (mon_ack),
        .mon_rdata   (mon_rdata),
        .ld_req      (ld_req),
        .ld_adr      (ld_adr),
        .ld_wdata    (ld_wdata),
        .ld_ack      (ld_ack),
        .cpu_halt    (cpu_halt),
        .rst_pipe    (rst_pipe),
        .i_read_sel  (i_read_sel),
        .i_ram_radr  (i_ram_radr),
        .i_ram_rdata (i_ram_rdata),
        .i_ram_wadr  (i_ram_wadr),
        .i_ram_wdata (i_ram_wdata),
        .i_ram_wen   (i_ram_wen)
    );

    // Synchronous-read RAM; the monitor's word is preloaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            mem[MADR] <= DB;
        end else if (i_ram_wen) begin
            mem[i_ram_wadr] <= i_ram_wdata;
        end
        i_ram_rdata <= mem[i_ram_radr];
    end

    typedef struct {
        logic        run, mreq, mwe, lreq;
        logic [5:0]  ctl;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic run, input logic mreq, input logic mwe,
                                input logic lreq, input logic [5:0] ctl, input logic [31:0] rd);
        vec_t v;
        v.run = run; v.mreq = mreq; v.mwe = mwe; v.lreq = lreq; v.ctl = ctl; v.rd = rd;
        return v;
    endfunction

    function automatic logic [5:0] ctl_now();
        return {cpu_halt, rst_pipe, i_read_sel, i_ram_wen, mon_ack, ld_ack};
    endfunction

    function automatic logic [151:0] all_out();
        return {ctl_now(), i_ram_radr, i_ram_wadr, i_ram_wdata, mon_rdata, 40'd0};
    endfunction

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t v, input int idx);
        logic [IW-1:0] ew, er;
        logic [31:0]   ewd;
        cpu_run = v.run; mon_req = v.mreq; mon_we = v.mwe; ld_req = v.lreq;
        @(negedge clk);
        ew  = v.ctl[2] ? (v.ctl[0] ? LADR : MADR) : '0;
        ewd = v.ctl[2] ? (v.ctl[0] ? LWD : MWD) : 32'd0;
        er  = v.ctl[3] ? MADR : '0;
        check($sformatf("row%0d_ctl", idx), {146'd0, ctl_now()}, {146'd0, v.ctl});
        check($sformatf("row%0d_data", idx),
              {64'd0, i_ram_wadr, i_ram_wdata, i_ram_radr, mon_rdata},
              {64'd0, ew, ewd, er, v.rd});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  got;
        rst = 1'b1;
        cpu_run = 0; mon_req = 0; mon_we = 0; ld_req = 0;
        mon_adr = MADR; mon_wdata = MWD; ld_adr = LADR; ld_wdata = LWD;

        // run, mreq, mwe, lreq, {halt,rst_pipe,rsel,wen,mack,lack}, mon_rdata
        tv.push_back(mk(0,0,0,0,6'b000000,0));
        // loader write, cpu stopped
        tv.push_back(mk(0,0,0,1,6'b000000,0));
        tv.push_back(mk(0,0,0,1,6'b100101,0));
        tv.push_back(mk(0,0,0,0,6'b100000,0));
        tv.push_back(mk(0,0,0,0,6'b010000,0));
        tv.push_back(mk(0,0,0,0,6'b000000,0));
        // both write together, cpu running: one drain, monitor then loader, one flush
        tv.push_back(mk(1,1,1,1,6'b000000,0));
        tv.push_back(mk(1,1,1,1,6'b100000,0));
        tv.push_back(mk(1,1,1,1,6'b100000,0));
        tv.push_back(mk(1,1,1,1,6'b100000,0));
        tv.push_back(mk(1,1,1,1,6'b100110,0));
        tv.push_back(mk(1,0,1,1,6'b100000,0));
        tv.push_back(mk(1,0,1,1,6'b100101,0));
        tv.push_back(mk(1,0,1,0,6'b100000,0));
        tv.push_back(mk(1,0,1,0,6'b010000,0));
        tv.push_back(mk(1,0,1,0,6'b000000,0));
        // monitor read, cpu running
        tv.push_back(mk(1,1,0,0,6'b000000,0));
        tv.push_back(mk(1,1,0,0,6'b100000,0));
        tv.push_back(mk(1,1,0,0,6'b100000,0));
        tv.push_back(mk(1,1,0,0,6'b100000,0));
        tv.push_back(mk(1,1,0,0,6'b101000,0));
        tv.push_back(mk(1,1,0,0,6'b101000,0));
        tv.push_back(mk(1,1,0,0,6'b100010,DB));
        tv.push_back(mk(1,0,0,0,6'b010000,DB));
        tv.push_back(mk(1,0,0,0,6'b000000,DB));
        // second contention: loader wins this time
        tv.push_back(mk(0,1,1,1,6'b000000,DB));
        tv.push_back(mk(0,1,1,1,6'b100101,DB));
        tv.push_back(mk(0,1,1,0,6'b100000,DB));
        tv.push_back(mk(0,1,1,0,6'b100110,DB));
        tv.push_back(mk(0,0,1,0,6'b100000,DB));
        tv.push_back(mk(0,0,1,0,6'b010000,DB));
        tv.push_back(mk(0,0,1,0,6'b000000,DB));
        // monitor read arriving in the RESUME cycle of a loader write
        tv.push_back(mk(0,0,0,1,6'b000000,DB));
        tv.push_back(mk(0,0,0,1,6'b100101,DB));
        tv.push_back(mk(0,0,0,0,6'b100000,DB));
        tv.push_back(mk(0,1,0,0,6'b010000,DB));
        tv.push_back(mk(0,1,0,0,6'b000000,DB));
        tv.push_back(mk(0,1,0,0,6'b101000,DB));
        tv.push_back(mk(0,1,0,0,6'b101000,DB));
        tv.push_back(mk(0,1,0,0,6'b100010,DB));
        tv.push_back(mk(0,0,0,0,6'b010000,DB));
        tv.push_back(mk(0,0,0,0,6'b000000,DB));
        // request withdrawn during drain: resume without flush
        tv.push_back(mk(1,0,0,1,6'b000000,DB));
        tv.push_back(mk(1,0,0,0,6'b100000,DB));
        tv.push_back(mk(1,0,0,0,6'b000000,DB));
        tv.push_back(mk(1,0,0,0,6'b000000,DB));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_out(), 152'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tv[i]) apply_row(tv[i], i);

        // reset asserted while a read sits in RDATA
        cpu_run = 0; mon_req = 1; mon_we = 0; ld_req = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rdata_state_sel", {151'd0, i_read_sel}, 152'd1);
        rst = 1'b1;
        #1 check("mid_reset_outputs", all_out(), 152'd0);
        @(posedge clk); #1;
        check("mid_reset_no_ack", all_out(), 152'd0);
        rst = 1'b0;
        got = 0; lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mon_ack) begin
                got = 1; lat = k;
                break;
            end
        end
        check("reread_ack_seen", {151'd0, got}, 152'd1);
        check("reread_latency", {120'd0, 32'(lat)}, {120'd0, 32'd3});
        check("reread_data", {120'd0, mon_rdata}, {120'd0, DB});
        @(posedge clk); #1;
        mon_req = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_idle_ctl", {146'd0, ctl_now()}, 152'd0);
        check("loader_word_in_ram", {120'd0, mem[LADR]}, {120'd0, LWD});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
